// File: rtl/ccff_chain_programmer.sv
// Programs a serial configuration flip-flop chain from a word stream and reads it
// back non-destructively by recirculating the tail into the head.
module ccff_chain_programmer #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start_load,
  input  logic              start_readback,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_FETCH,
    LD_SHIFT,
    RB_SHIFT,
    RB_HOLD,
    FIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] ld_word;
  logic [WORD_W-1:0] rb_acc;
  logic              head_q;
  logic              head_loop;

  logic [WORD_W-1:0] ld_next;
  logic [WORD_W-1:0] rb_cap;

  assign ld_next = ld_word >> 1;
  assign rb_cap  = rb_acc | (WORD_W'(ccff_tail) << bit_idx);

  // During readback the tail is looped straight back so the chain rotates in place.
  assign ccff_head = head_loop ? ccff_tail : head_q;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      ld_word      <= '0;
      rb_acc       <= '0;
      head_q       <= 1'b0;
      head_loop    <= 1'b0;
      cfg_ready    <= 1'b0;
      rb_data      <= '0;
      rb_valid     <= 1'b0;
      chain_clk_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (start_load) begin
            state     <= LD_FETCH;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end else if (start_readback) begin
            state        <= RB_SHIFT;
            busy         <= 1'b1;
            chain_clk_en <= 1'b1;
            head_loop    <= 1'b1;
            bit_idx      <= '0;
            rb_acc       <= '0;
          end
        end

        LD_FETCH: begin
          if (cfg_valid) begin
            state        <= LD_SHIFT;
            cfg_ready    <= 1'b0;
            chain_clk_en <= 1'b1;
            head_q       <= cfg_data[0];
            ld_word      <= cfg_data;
            bit_idx      <= '0;
          end
        end

        LD_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          bit_idx <= bit_idx + IDX_W'(1);
          ld_word <= ld_next;
          head_q  <= ld_next[0];
          // Chain length ends the load even mid-word; leftover word bits are dropped.
          if (bit_cnt == CNT_LAST) begin
            state        <= FIN;
            chain_clk_en <= 1'b0;
            head_q       <= 1'b0;
            done         <= 1'b1;
          end else if (bit_idx == IDX_LAST) begin
            state        <= LD_FETCH;
            chain_clk_en <= 1'b0;
            head_q       <= 1'b0;
            cfg_ready    <= 1'b1;
          end
        end

        RB_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          bit_idx <= bit_idx + IDX_W'(1);
          rb_acc  <= rb_cap;
          if (bit_cnt == CNT_LAST || bit_idx == IDX_LAST) begin
            state        <= RB_HOLD;
            chain_clk_en <= 1'b0;
            head_loop    <= 1'b0;
            rb_data      <= rb_cap;
            rb_valid     <= 1'b1;
          end
        end

        RB_HOLD: begin
          if (rb_ready) begin
            rb_valid <= 1'b0;
            if (bit_cnt == CNT_FULL) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state        <= RB_SHIFT;
              chain_clk_en <= 1'b1;
              head_loop    <= 1'b1;
              bit_idx      <= '0;
              rb_acc       <= '0;
            end
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Randomized bench for ccff_chain_programmer driving a behavioural 10-bit chain;
// expectations come from a bit-stream model of the loaded words.
module tb_ccff_chain_programmer;

  localparam int CL = 10;
  localparam int WW = 4;
  localparam int NW = (CL + WW - 1) / WW;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic          start_load = 1'b0;
  logic          start_readback = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          rb_ready = 1'b1;
  logic          ccff_head;
  logic          ccff_tail;
  logic          chain_clk_en;
  logic          busy;
  logic          done;

  ccff_chain_programmer #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .start_load     (start_load),
    .start_readback (start_readback),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .rb_data        (rb_data),
    .rb_valid       (rb_valid),
    .rb_ready       (rb_ready),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .chain_clk_en   (chain_clk_en),
    .busy           (busy),
    .done           (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: head enters at bit 0, tail leaves from the top bit.
  logic [CL-1:0] chain = '0;
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) if (chain_clk_en) chain <= {chain[CL-2:0], ccff_head};

  int            shifts = 0;
  int            done_cnt = 0;
  int            rbv_cycles = 0;
  int            viol = 0;
  logic          head_seq[$];
  logic [WW-1:0] rb_q[$];
  logic          prev_rbv = 1'b0;
  logic          prev_rbr = 1'b0;
  logic [WW-1:0] prev_rbd = '0;

  always @(negedge prog_clk) begin
    if (chain_clk_en) begin
      shifts <= shifts + 1;
      head_seq.push_back(ccff_head);
    end else if (ccff_head) begin
      viol <= viol + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rb_valid) rbv_cycles <= rbv_cycles + 1;
    if (rb_valid && rb_ready) rb_q.push_back(rb_data);
    if ((rb_valid && chain_clk_en) ||
        (prev_rbv && !prev_rbr && !(rb_valid && rb_data == prev_rbd)))
      viol <= viol + 1;
    prev_rbv <= rb_valid;
    prev_rbr <= rb_ready;
    prev_rbd <= rb_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  // Reference model: the word list flattened into the serial bit stream.
  logic [WW-1:0] wl[NW];

  function automatic logic [CL-1:0] stream_bits();
    logic [CL-1:0] b;
    for (int k = 0; k < CL; k++) b[k] = wl[k / WW][k % WW];
    return b;
  endfunction

  function automatic logic [CL-1:0] exp_chain();
    logic [CL-1:0] b;
    logic [CL-1:0] c;
    b = stream_bits();
    for (int k = 0; k < CL; k++) c[CL-1-k] = b[k];
    return c;
  endfunction

  function automatic logic [WW-1:0] exp_rb(input int j);
    logic [CL-1:0] b;
    logic [WW-1:0] r;
    b = stream_bits();
    r = '0;
    for (int t = 0; t < WW; t++) if (j * WW + t < CL) r[t] = b[j * WW + t];
    return r;
  endfunction

  task automatic run_load(input int stall, input bit both, input bit rb_mid);
    int s0, d0, h0, r0, n, late;
    logic [CL-1:0] hs;
    s0 = shifts; d0 = done_cnt; h0 = head_seq.size(); r0 = rbv_cycles; late = 0;
    start_load = 1'b1;
    start_readback = both;
    tick;
    start_load = 1'b0;
    start_readback = 1'b0;
    chk("busy_load", busy, 1);
    for (int i = 0; i < NW; i++) begin
      if (i > 0 && stall > 0) begin
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 50) begin tick; n++; end
        repeat (stall) begin chk("stall_no_shift", chain_clk_en, 0); tick; end
      end
      cfg_valid = 1'b1;
      cfg_data = wl[i];
      n = 0;
      while (!cfg_ready && n < 50) begin tick; n++; end
      chk("fetch_ready", cfg_ready, 1);
      tick;
      if (i == 0 && rb_mid) begin
        start_readback = 1'b1;
        tick;
        start_readback = 1'b0;
      end
    end
    cfg_data = WW'($urandom);
    n = 0;
    while (!done && n < 60) begin
      if (cfg_ready) late++;
      tick;
      n++;
    end
    chk("load_done", done, 1);
    tick;
    cfg_valid = 1'b0;
    tick;
    chk("ready_after_last", late, 0);
    chk("load_shifts", shifts - s0, CL);
    chk("load_done_cnt", done_cnt - d0, 1);
    chk("load_no_rb", rbv_cycles - r0, 0);
    for (int k = 0; k < CL; k++) hs[k] = (h0 + k < head_seq.size()) ? head_seq[h0 + k] : 1'bx;
    chk("head_seq", hs, stream_bits());
    chk("chain_after_load", chain, exp_chain());
  endtask

  task automatic run_readback(input int hold_word, input int hold_n);
    int s0, d0, q0, v0, k, n;
    s0 = shifts; d0 = done_cnt; q0 = rb_q.size(); v0 = rbv_cycles; k = 0; n = 0;
    rb_ready = 1'b1;
    start_readback = 1'b1;
    tick;
    start_readback = 1'b0;
    chk("busy_rb", busy, 1);
    while (!done && n < 200) begin
      if (rb_valid && k == hold_word) begin
        rb_ready = 1'b0;
        repeat (hold_n) tick;
        rb_ready = 1'b1;
        n += hold_n;
      end
      if (rb_valid) k++;
      tick;
      n++;
    end
    chk("rb_done", done, 1);
    tick;
    chk("rb_shifts", shifts - s0, CL);
    chk("rb_done_cnt", done_cnt - d0, 1);
    chk("rb_word_cnt", rb_q.size() - q0, NW);
    for (int j = 0; j < NW; j++)
      if (q0 + j < rb_q.size()) chk("rb_word", rb_q[q0 + j], exp_rb(j));
    chk("rb_valid_cycles", rbv_cycles - v0, (hold_word < NW) ? NW + hold_n : NW);
    chk("chain_restored", chain, exp_chain());
  endtask

  initial begin
    int s0, s1, n, wi;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset_outputs", {cfg_ready, rb_valid, rb_data, ccff_head, chain_clk_en, busy, done}, 0);
    #2 pReset = 1'b0;
    tick;

    wl[0] = 4'hA; wl[1] = 4'h5; wl[2] = 4'h3;
    chk("directed_stream", stream_bits(), 10'b1101011010);
    run_load(0, 1'b0, 1'b0);
    run_load(5, 1'b0, 1'b0);
    run_readback(NW, 0);
    run_readback(1, 7);

    for (int i = 0; i < NW; i++) wl[i] = WW'($urandom);
    run_load(0, 1'b1, 1'b1);
    run_readback(NW, 0);

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NW; i++) wl[i] = WW'($urandom);
      run_load(int'($urandom_range(0, 4)), 1'b0, 1'b0);
      run_readback(int'($urandom_range(0, NW)), int'($urandom_range(1, 6)));
    end

    // Reset in the middle of a load after six shifts.
    for (int i = 0; i < NW; i++) wl[i] = WW'($urandom);
    s0 = shifts; n = 0; wi = 0;
    start_load = 1'b1;
    tick;
    start_load = 1'b0;
    cfg_valid = 1'b1;
    while (shifts - s0 < 6 && n < 100) begin
      cfg_data = wl[(wi < NW) ? wi : NW - 1];
      if (cfg_ready) wi++;
      tick;
      n++;
    end
    chk("pre_reset_busy", busy, 1);
    #2 pReset = 1'b1;
    #1;
    chk("midop_reset_outputs", {cfg_ready, rb_valid, rb_data, ccff_head, chain_clk_en, busy, done}, 0);
    cfg_valid = 1'b0;
    s1 = shifts;
    repeat (2) tick;
    #2 pReset = 1'b0;
    repeat (3) tick;
    chk("no_shift_after_reset", shifts - s1, 0);
    chk("idle_after_reset", busy, 0);
    run_load(int'($urandom_range(0, 3)), 1'b0, 1'b0);
    run_readback(NW, 0);

    chk("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
